// File: rtl/matmul_pkg.sv
// Shared constants for the matmul stream controller: default geometry, frame sizes and
// the state codes used by the top-level sequencer and the result reader.
package matmul_pkg;

  localparam int unsigned Width        = 8;
  localparam int unsigned ADepthBits   = 3;
  localparam int unsigned BDepthBits   = 2;
  localparam int unsigned ResDepthBits = 1;

  localparam int unsigned NA  = 2 ** ADepthBits;
  localparam int unsigned NB  = 2 ** BDepthBits;
  localparam int unsigned NR  = 2 ** ResDepthBits;
  localparam int unsigned NIN = NA + NB;

  localparam int unsigned KW = $clog2(NIN + 1);
  localparam int unsigned JW = $clog2(NR + 1);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StReadInputs = 3'd1;
  localparam logic [2:0] StCompute    = 3'd2;
  localparam logic [2:0] StFetch      = 3'd3;
  localparam logic [2:0] StWait       = 3'd4;
  localparam logic [2:0] StSend       = 3'd5;

endpackage

// File: rtl/res_stream_reader.sv
// Streams RES_RAM out over the master AXI-Stream port: FETCH, WAIT, SEND per word,
// TLAST on the final word, data held under back-pressure.
module res_stream_reader
  import matmul_pkg::*;
#(
  parameter int unsigned width          = Width,
  parameter int unsigned RES_depth_bits = ResDepthBits
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      go,
  output logic                      finished,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic [width-1:0]          m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast
);

  logic [2:0]                state_q;
  logic [RES_depth_bits-1:0] j_q;
  logic [width-1:0]          m_tdata_q;
  logic                      m_tvalid_q;
  logic                      m_tlast_q;

  assign RES_read_en      = (state_q == StFetch);
  assign RES_read_address = j_q;
  assign m_tdata          = m_tdata_q;
  assign m_tvalid         = m_tvalid_q;
  assign m_tlast          = m_tlast_q;
  assign finished         = (state_q == StSend) && m_tready && m_tlast_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      j_q        <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (go) state_q <= StFetch;
        end
        StFetch: begin
          state_q <= StWait;
        end
        StWait: begin
          // Synchronous RAM data for address j is valid in this cycle.
          m_tdata_q  <= RES_read_data_out;
          m_tvalid_q <= 1'b1;
          m_tlast_q  <= (j_q == {RES_depth_bits{1'b1}});
          state_q    <= StSend;
        end
        StSend: begin
          if (m_tready) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            if (m_tlast_q) begin
              j_q     <= '0;
              state_q <= StIdle;
            end else begin
              j_q     <= j_q + 1'b1;
              state_q <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/matmul_stream_controller.sv
// Top-level sequencer: loads A then B from the slave stream, runs the engine Start/Done
// handshake, then hands off to res_stream_reader to stream the results.
module matmul_stream_controller
  import matmul_pkg::*;
#(
  parameter int unsigned width          = Width,
  parameter int unsigned A_depth_bits   = ADepthBits,
  parameter int unsigned B_depth_bits   = BDepthBits,
  parameter int unsigned RES_depth_bits = ResDepthBits
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [width-1:0]          s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  output logic [width-1:0]          m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      A_write_en,
  output logic [A_depth_bits-1:0]   A_write_address,
  output logic [width-1:0]          A_write_data_in,
  output logic                      B_write_en,
  output logic [B_depth_bits-1:0]   B_write_address,
  output logic [width-1:0]          B_write_data_in,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic                      mm_start,
  input  logic                      mm_done
);

  localparam int unsigned NumA  = 2 ** A_depth_bits;
  localparam int unsigned NumB  = 2 ** B_depth_bits;
  localparam int unsigned NumIn = NumA + NumB;
  localparam int unsigned CntW  = $clog2(NumIn + 1);

  logic [2:0]              state_q;
  logic [CntW-1:0]         k_q;
  logic [CntW-1:0]         k_b_off;
  logic                    s_tready_q;
  logic                    mm_start_q;
  logic                    go_q;
  logic                    reader_finished;
  logic                    a_we_q, b_we_q;
  logic [A_depth_bits-1:0] a_addr_q;
  logic [B_depth_bits-1:0] b_addr_q;
  logic [width-1:0]        a_data_q, b_data_q;
  logic                    hs;
  logic                    unused_bits;

  // Framing is purely count-based, so TLAST is deliberately dropped.
  assign unused_bits = ^{s_tlast, k_b_off};

  assign hs      = s_tvalid && s_tready_q;
  assign k_b_off = k_q - CntW'(NumA);

  assign s_tready        = s_tready_q;
  assign mm_start        = mm_start_q;
  assign A_write_en      = a_we_q;
  assign A_write_address = a_addr_q;
  assign A_write_data_in = a_data_q;
  assign B_write_en      = b_we_q;
  assign B_write_address = b_addr_q;
  assign B_write_data_in = b_data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      k_q        <= '0;
      s_tready_q <= 1'b0;
      mm_start_q <= 1'b0;
      go_q       <= 1'b0;
      a_we_q     <= 1'b0;
      a_addr_q   <= '0;
      a_data_q   <= '0;
      b_we_q     <= 1'b0;
      b_addr_q   <= '0;
      b_data_q   <= '0;
    end else begin
      a_we_q <= 1'b0;
      b_we_q <= 1'b0;
      go_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (s_tvalid) begin
            state_q    <= StReadInputs;
            s_tready_q <= 1'b1;
          end
        end
        StReadInputs: begin
          if (hs) begin
            if (k_q < CntW'(NumA)) begin
              a_we_q   <= 1'b1;
              a_addr_q <= k_q[A_depth_bits-1:0];
              a_data_q <= s_tdata;
            end else begin
              b_we_q   <= 1'b1;
              b_addr_q <= k_b_off[B_depth_bits-1:0];
              b_data_q <= s_tdata;
            end
            if (k_q == CntW'(NumIn - 1)) begin
              k_q        <= '0;
              s_tready_q <= 1'b0;
              state_q    <= StCompute;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        StCompute: begin
          // Done only counts once Start is actually visible to the engine.
          if (mm_start_q && mm_done) begin
            mm_start_q <= 1'b0;
            go_q       <= 1'b1;
            state_q    <= StFetch;
          end else begin
            mm_start_q <= 1'b1;
          end
        end
        StFetch: begin
          // The reader walks FETCH/WAIT/SEND; the top parks here until it finishes.
          if (reader_finished) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  res_stream_reader #(
    .width          (width),
    .RES_depth_bits (RES_depth_bits)
  ) u_reader (
    .clk               (clk),
    .resetn            (resetn),
    .go                (go_q),
    .finished          (reader_finished),
    .RES_read_en       (RES_read_en),
    .RES_read_address  (RES_read_address),
    .RES_read_data_out (RES_read_data_out),
    .m_tdata           (m_tdata),
    .m_tvalid          (m_tvalid),
    .m_tready          (m_tready),
    .m_tlast           (m_tlast)
  );

endmodule

// File: tb/tb_matmul_stream_controller.sv
// Randomized self-checking bench: RAM and engine models around the controller, with a
// reference dot-product model computed directly from the stimulus frame.
module tb_matmul_stream_controller;

  localparam int NIN = 12;
  localparam int NR  = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tready, s_tlast;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tready, m_tlast;
  logic       A_write_en, B_write_en, RES_read_en;
  logic [2:0] A_write_address;
  logic [1:0] B_write_address;
  logic [0:0] RES_read_address;
  logic [7:0] A_write_data_in, B_write_data_in, RES_read_data_out;
  logic       mm_start, mm_done;

  always #5 clk = ~clk;

  matmul_stream_controller dut (
    .clk               (clk),
    .resetn            (resetn),
    .s_tdata           (s_tdata),
    .s_tvalid          (s_tvalid),
    .s_tready          (s_tready),
    .s_tlast           (s_tlast),
    .m_tdata           (m_tdata),
    .m_tvalid          (m_tvalid),
    .m_tready          (m_tready),
    .m_tlast           (m_tlast),
    .A_write_en        (A_write_en),
    .A_write_address   (A_write_address),
    .A_write_data_in   (A_write_data_in),
    .B_write_en        (B_write_en),
    .B_write_address   (B_write_address),
    .B_write_data_in   (B_write_data_in),
    .RES_read_en       (RES_read_en),
    .RES_read_address  (RES_read_address),
    .RES_read_data_out (RES_read_data_out),
    .mm_start          (mm_start),
    .mm_done           (mm_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RAM models: A 8x8, B 4x8, RES 2x8 with one-cycle synchronous read.
  logic [7:0] a_ram [8];
  logic [7:0] b_ram [4];
  logic [7:0] res_mem [2];
  logic [7:0] res_rdata = '0;
  assign RES_read_data_out = res_rdata;

  always @(posedge clk) begin
    if (A_write_en) a_ram[A_write_address] <= A_write_data_in;
    if (B_write_en) b_ram[B_write_address] <= B_write_data_in;
    if (RES_read_en) res_rdata <= res_mem[RES_read_address];
  end

  // Engine model: 2x4 A times 4x1 B, done 20 cycles after Start rises.
  function automatic logic [7:0] engine_row(input int r);
    logic [7:0] s = '0;
    for (int k = 0; k < 4; k++) s = s + a_ram[r*4+k] * b_ram[k];
    return s;
  endfunction

  int   eng_cnt = 0;
  logic done_r = 1'b0;
  logic force_done = 1'b0;
  assign mm_done = done_r | force_done;

  always @(posedge clk) begin
    if (!mm_start) begin
      eng_cnt <= 0;
      done_r  <= 1'b0;
    end else if (eng_cnt == 19) begin
      eng_cnt <= eng_cnt + 1;
      done_r  <= 1'b1;
      for (int r = 0; r < NR; r++) res_mem[r] <= engine_row(r);
    end else if (eng_cnt < 19) begin
      eng_cnt <= eng_cnt + 1;
    end
  end

  // Monitors sample mid-cycle; handshakes seen here complete on the next rising edge.
  bit [7:0]   a_seen;
  bit [3:0]   b_seen;
  int         wr_cnt, dup_cnt;
  logic [8:0] out_q [$];

  always @(negedge clk) begin
    if (A_write_en) begin
      wr_cnt++;
      if (a_seen[A_write_address]) dup_cnt++;
      a_seen[A_write_address] = 1'b1;
    end
    if (B_write_en) begin
      wr_cnt++;
      if (b_seen[B_write_address]) dup_cnt++;
      b_seen[B_write_address] = 1'b1;
    end
    if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
  end

  logic [7:0] stim [NIN];

  function automatic logic [7:0] ref_result(input int r);
    logic [7:0] s = '0;
    for (int k = 0; k < 4; k++) s = s + stim[r*4+k] * stim[8+k];
    return s;
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({s_tready, m_tvalid, m_tlast, m_tdata, A_write_en, A_write_address,
                A_write_data_in, B_write_en, B_write_address, B_write_data_in,
                RES_read_en, RES_read_address, mm_start});
  endfunction

  task automatic fixed_stim();
    for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
    for (int i = 0; i < 4; i++) stim[8+i] = 8'(i + 1);
  endtask

  task automatic random_stim();
    for (int i = 0; i < NIN; i++) stim[i] = 8'($urandom_range(0, 255));
  endtask

  // vmode: 0 valid held high, 1 toggling, 2 random. Stops early once stop_at words taken.
  task automatic drive_inputs(input int vmode, input int tlast_idx, input int stop_at);
    int i = 0;
    int cyc = 0;
    bit tog = 1'b0;
    bit hs;
    while (i < NIN && i != stop_at && cyc < 200) begin
      case (vmode)
        0:       s_tvalid = 1'b1;
        1:       begin s_tvalid = tog; tog = ~tog; end
        default: s_tvalid = 1'($urandom_range(0, 1));
      endcase
      s_tdata = stim[i];
      s_tlast = (i == tlast_idx);
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      cyc++;
      if (hs) i++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (stop_at < 0) check_eq("input_words_accepted", 64'(i), 64'(NIN));
  endtask

  task automatic run_frame(input int vmode, input int tlast_idx, input int stall,
                           input bit fd, input bit rmode);
    int cyc;
    a_seen  = '0;
    b_seen  = '0;
    wr_cnt  = 0;
    dup_cnt = 0;
    out_q.delete();
    force_done = fd;
    drive_inputs(vmode, tlast_idx, -1);
    force_done = 1'b0;
    @(negedge clk);
    check_eq("compute_entry_mm_start_low", 64'(mm_start), 64'd0);
    check_eq("compute_s_tready_low", 64'(s_tready), 64'd0);
    @(negedge clk);
    check_eq("compute_mm_start_high", 64'(mm_start), 64'd1);
    @(posedge clk); #1;

    if (stall > 0) begin
      m_tready = 1'b0;
      cyc = 0;
      while (!m_tvalid && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check_eq("first_word_valid_before_timeout", 64'(m_tvalid), 64'd1);
      for (int s = 0; s < stall; s++) begin
        check_eq("stall_m_tvalid", 64'(m_tvalid), 64'd1);
        check_eq("stall_m_tdata", 64'(m_tdata), 64'(ref_result(0)));
        check_eq("stall_no_fetch", 64'(RES_read_en), 64'd0);
        @(posedge clk); #1;
      end
      m_tready = 1'b1;
    end else begin
      m_tready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    cyc = 0;
    while (out_q.size() < NR && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (rmode) m_tready = 1'($urandom_range(0, 1));
    end
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check_eq("out_word_count", 64'(out_q.size()), 64'(NR));
    for (int r = 0; r < out_q.size(); r++) begin
      check_eq("out_data", 64'(out_q[r][7:0]), 64'(ref_result(r)));
      check_eq("out_last", 64'(out_q[r][8]), 64'(r == NR - 1));
    end
    for (int i = 0; i < 8; i++) check_eq("a_ram_content", 64'(a_ram[i]), 64'(stim[i]));
    for (int i = 0; i < 4; i++) check_eq("b_ram_content", 64'(b_ram[i]), 64'(stim[8+i]));
    check_eq("write_pulse_count", 64'(wr_cnt), 64'(NIN));
    check_eq("duplicate_write_addr", 64'(dup_cnt), 64'd0);
    check_eq("idle_after_frame", 64'({s_tready, m_tvalid, mm_start}), 64'd0);
  endtask

  task automatic reset_mid_frame();
    drive_inputs(0, -1, 7);
    resetn = 1'b0;
    #1;
    check_eq("mid_reset_outputs_zero", all_outputs(), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("post_reset_idle", all_outputs(), 64'd0);
  endtask

  initial begin
    resetn   = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    #2;
    check_eq("reset_outputs_zero", all_outputs(), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    fixed_stim();
    run_frame(0, -1, 0, 1'b0, 1'b0);
    run_frame(1, -1, 0, 1'b0, 1'b0);
    run_frame(0, -1, 10, 1'b0, 1'b0);
    run_frame(0, 4, 0, 1'b0, 1'b0);

    reset_mid_frame();
    random_stim();
    run_frame(0, -1, 0, 1'b0, 1'b0);

    random_stim();
    run_frame(0, -1, 0, 1'b1, 1'b0);

    repeat (4) begin
      random_stim();
      run_frame(2, int'($urandom_range(0, NIN - 1)), 0, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matmul_stream_controller.md
# matmul_stream_controller

Top-level sequencer for the AXI-Stream matrix-multiply coprocessor. Accepts a flat input stream and writes it into A_RAM (A elements first) and then B_RAM. Drives the matrix-multiply engine's Start/Done handshake, then reads RES_RAM back out as an output stream with TLAST on the final word. It sits between the AXI-Stream ports of the IP wrapper and the three RAMs plus the engine.

## Interface
- width, 8: bits per data word and per RAM location
- A_depth_bits, 3: A_RAM address bits; NA = 2**A_depth_bits words
- B_depth_bits, 2: B_RAM address bits; NB = 2**B_depth_bits words
- RES_depth_bits, 1: RES_RAM address bits; NR = 2**RES_depth_bits words

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- s_tdata  in  width  input stream data
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- s_tlast  in  1  input last (ignored; framing is count-based)
- m_tdata  out  width  output stream data
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tlast  out  1  high with final result word
- A_write_en / A_write_address / A_write_data_in  out  1 / A_depth_bits / width  A_RAM write port
- B_write_en / B_write_address / B_write_data_in  out  1 / B_depth_bits / width  B_RAM write port
- RES_read_en / RES_read_address  out  1 / RES_depth_bits  RES_RAM read port
- RES_read_data_out  in  width  RES_RAM synchronous read data
- mm_start  out  1  engine Start, level
- mm_done  in  1  engine Done, level

## Operation
- States: IDLE, READ_INPUTS, COMPUTE, FETCH, WAIT, SEND.
- IDLE: s_tready=0. Go to READ_INPUTS when s_tvalid=1; no word is accepted in this cycle.
- READ_INPUTS: s_tready=1. On each handshake with counter k:
  - k<NA: write A at address k.
  - otherwise: write B at address k-NA.
  - Write outputs are registered: the write is presented in the cycle after the handshake.
  - After the handshake with k=NA+NB-1, clear k and go to COMPUTE; s_tready drops in that same edge.
- COMPUTE: mm_start=1. When mm_done=1 is sampled, mm_start=0 on the next cycle and the state goes to FETCH with j=0.
- FETCH: RES_read_en=1, RES_read_address=j, for one cycle.
- WAIT: RAM data is valid; m_tdata <= RES_read_data_out at the end of this cycle.
- SEND: m_tvalid=1, m_tlast=(j==NR-1); m_tdata held stable until m_tready=1.
  - On handshake with j<NR-1: j+1, go to FETCH.
  - On handshake with j=NR-1: go to IDLE.
- s_tlast is ignored in all states: early or missing TLAST does not change counting.
- Write-enables are single-cycle pulses; the address and data registers hold their last value when enable is low.

## Timing
- Reset (async assert, sync release): state=IDLE, k=j=0. Every output is 0: s_tready, m_tvalid, m_tlast, m_tdata, all enables, addresses, write data, mm_start.
- resetn low mid-transfer or mid-compute aborts immediately; RAM contents are not cleared.
- Input throughput: 1 word/cycle. A/B write latency: 1 cycle after handshake.
- COMPUTE entry to mm_start high: 1 cycle (registered). mm_done sampled high to mm_start low: 1 cycle.
- Output: 3 cycles minimum per word (FETCH, WAIT, SEND). Back-pressure in SEND holds indefinitely.
- mm_done high in any state other than COMPUTE is ignored.
- s_tvalid high in COMPUTE/FETCH/WAIT/SEND is not accepted (s_tready=0).

## Structure
- Shared package matmul_pkg:
  - state enum
  - localparams NA, NB, NR, NIN=NA+NB
  - counter widths via $clog2(NIN+1) and $clog2(NR+1)
- One natural sub-module, res_stream_reader: owns FETCH/WAIT/SEND, j, and the m_* registers. Handshake with the top: go/finished pulses.

## Test plan
- Load A=1..8, B=1,2,3,4 with s_tvalid held high; engine model asserts mm_done 20 cycles after mm_start -> A/B RAMs hold the exact values; output stream is 30 then 70, with m_tlast only on 70.
- Same data with s_tvalid toggling every other cycle -> identical RAM contents, exactly 12 write pulses, no duplicate addresses.
- m_tready held low 10 cycles in SEND -> m_tdata=30 and m_tvalid stable throughout; second word is not fetched until the handshake.
- s_tlast asserted on word 5 -> ignored; all 12 words are still accepted before COMPUTE.
- resetn pulsed low on word 7 -> all outputs 0 in the same cycle; a fresh 12-word frame completes normally.
- mm_done forced high during READ_INPUTS -> no state change; COMPUTE still asserts mm_start.
